cpu_sequencer: RTL
==================

// Module: cpu_sequencer
// PURPOSE
//   Control sequencer for the 8-bit CPU. Sits directly downstream of the
//   instruction decoder and consumes its one-hot opcode lines
//   (LD/ADD/SUB/AND/OR/STO/HALT). It generates every datapath strobe in
//   order: the PC, MAR, memory, IR-latch (IIR), accumulator and ALU-op
//   controls. Instructions are two bytes (opcode, then operand address).
// PARAMETERS
//   CNT_W  8  width of retired-instruction counter instr_cnt (wraps)
// PORTS
//   clk        in   1      system clock, all state changes on posedge
//   rst_n      in   1      asynchronous active-low reset
//   run        in   1      level; 1 = keep fetching, 0 = stop at next fetch boundary
//   LD,ADD,SUB,AND,OR,STO,HALT  in 1 each  one-hot decoded opcode from decoder
//   PC_INC     out  1      PC <= PC+1 at next posedge
//   MAR_PC     out  1      MAR <= PC at next posedge
//   MAR_MEM    out  1      MAR <= memory data (operand address) at next posedge
//   MEM_RD     out  1      memory read enable, data drives bus
//   MEM_WR     out  1      memory write of accumulator at next posedge
//   IIR        out  1      IR load strobe; IR latches bus on its falling edge
//   ACC_LD     out  1      ACC <= ALU result at next posedge
//   ALU_OP     out  3      000 pass(LD) 001 ADD 010 SUB 011 AND 100 OR
//   busy       out  1      1 in any state except IDLE/HALTED
//   halted     out  1      1 in HALTED (HALT executed or illegal opcode)
//   fault      out  1      1 if halted because of illegal decode
//   instr_cnt  out  CNT_W  instructions retired (incl. HALT), wraps to 0
// BEHAVIOUR
//   - Moore FSM. All outputs registered and decoded from state. On rst_n=0
//     (async), state=IDLE and all outputs=0, including ALU_OP=000 and instr_cnt=0.
//   - States/outputs (one clock each):
//     IDLE : all 0. Go to F0 when run=1.
//     F0   : MAR_PC.                                    -> F1
//     F1   : MEM_RD, IIR=1.                             -> F2
//     F2   : IIR=0 (falling edge latches opcode), PC_INC. -> DEC
//     DEC  : sample decoder lines (settled since F2 start).
//            Exactly one of LD..STO set -> A0. HALT only -> HALTED, instr_cnt+1.
//            Zero or >1 lines set -> HALTED with fault=1, instr_cnt unchanged.
//     A0   : MAR_PC.                                    -> A1
//     A1   : MEM_RD, MAR_MEM, PC_INC.                   -> EX
//     EX   : LD/ALU ops: MEM_RD, ACC_LD, ALU_OP per opcode.
//            STO: MEM_WR, ALU_OP=000. instr_cnt+1.
//            Next state is F0 if run=1, else IDLE.
//     HALTED: halted=1. Sticky; only rst_n leaves it. run is ignored.
//   - The opcode class is captured into an internal register in DEC. EX uses
//     that register, so decoder changes after DEC have no effect.
//   - Latency: LD/ADD/SUB/AND/OR/STO take 7 clocks (F0..EX). HALT takes 4
//     clocks (F0..DEC), then halted=1.
//   - run deasserted mid-instruction: the current instruction completes, then
//     the FSM enters IDLE. There is no partial instruction.
//   - Each IIR low->high->low pulse is exactly one clock wide. This gives one
//     falling edge per fetch.
//   - Reset during F1 forces IIR to 0 asynchronously. The IR may latch a
//     spurious byte; this is harmless because the next fetch overwrites it.
//   - instr_cnt is modulo 2^CNT_W: 8'hFF+1 -> 8'h00.
//   - MEM_RD and MEM_WR are never high together. MAR_PC and MAR_MEM are never
//     high together.
// TESTING
//   1. Reset, run=1, program LD 0x10 -> trace is F0,F1,F2,DEC,A0,A1,EX.
//      ACC_LD=1 with ALU_OP=000 in cycle 7, PC_INC pulses in cycles 3 and 6,
//      instr_cnt=1.
//   2. Sequence ADD,SUB,AND,OR,STO -> ALU_OP 001/010/011/100 in the EX cycles.
//      STO gives MEM_WR=1 and ACC_LD=0. instr_cnt=5 after 35 clocks.
//   3. HALT opcode -> halted=1 from clock 5 onward, fault=0, busy=0,
//      instr_cnt+1. Toggling run does not change state.
//   4. Force all decoder lines 0, then two lines 1 -> HALTED with fault=1.
//      instr_cnt unchanged.
//   5. Drop run during A0 -> EX still executes, then IDLE, all outputs 0.
//      Raise run -> F0 next clock.
//   6. Assert rst_n=0 mid-EX -> all outputs 0 asynchronously, no MEM_WR pulse
//      completes. Preload instr_cnt=8'hFF, then retire one -> 8'h00.

Source files
------------

// File: rtl/cpu_sequencer.sv
// Moore control sequencer for the 8-bit CPU: walks fetch/decode/operand/execute
// states and emits registered datapath strobes decoded from the next state.
module cpu_sequencer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             LD,
  input  logic             ADD,
  input  logic             SUB,
  input  logic             AND,
  input  logic             OR,
  input  logic             STO,
  input  logic             HALT,
  output logic             PC_INC,
  output logic             MAR_PC,
  output logic             MAR_MEM,
  output logic             MEM_RD,
  output logic             MEM_WR,
  output logic             IIR,
  output logic             ACC_LD,
  output logic [2:0]       ALU_OP,
  output logic             busy,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [3:0] {
    S_IDLE, S_F0, S_F1, S_F2, S_DEC, S_A0, S_A1, S_EX, S_HALTED
  } state_e;

  typedef struct packed {
    logic       pc_inc;
    logic       mar_pc;
    logic       mar_mem;
    logic       mem_rd;
    logic       mem_wr;
    logic       iir;
    logic       acc_ld;
    logic [2:0] alu_op;
    logic       busy;
    logic       halted;
  } ctl_t;

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic             sto_q, sto_d;
  logic             fault_q, fault_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ctl_t             ctl_q, ctl_d;

  logic [6:0] lines;
  logic       one_hot;

  always_comb begin
    lines   = {HALT, STO, OR, AND, SUB, ADD, LD};
    one_hot = (lines != 7'd0) && ((lines & (lines - 7'd1)) == 7'd0);

    state_d = state_q;
    op_d    = op_q;
    sto_d   = sto_q;
    fault_d = fault_q;
    cnt_d   = cnt_q;

    case (state_q)
      S_IDLE:   if (run) state_d = S_F0;
      S_F0:     state_d = S_F1;
      S_F1:     state_d = S_F2;
      S_F2:     state_d = S_DEC;
      S_DEC: begin
        // Opcode class is frozen here; EX never looks at the decoder again.
        if (!one_hot) begin
          state_d = S_HALTED;
          fault_d = 1'b1;
        end else if (HALT) begin
          state_d = S_HALTED;
          cnt_d   = cnt_q + CNT_W'(1);
        end else begin
          state_d = S_A0;
          sto_d   = STO;
          op_d    = ADD ? 3'b001 :
                    SUB ? 3'b010 :
                    AND ? 3'b011 :
                    OR  ? 3'b100 : 3'b000;
        end
      end
      S_A0:     state_d = S_A1;
      S_A1:     state_d = S_EX;
      S_EX: begin
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = run ? S_F0 : S_IDLE;
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the flops line up with state_q.
  always_comb begin
    ctl_d = '0;
    case (state_d)
      S_F0, S_A0: ctl_d.mar_pc = 1'b1;
      S_F1: begin
        ctl_d.mem_rd = 1'b1;
        ctl_d.iir    = 1'b1;
      end
      S_F2:       ctl_d.pc_inc = 1'b1;
      S_A1: begin
        ctl_d.mem_rd  = 1'b1;
        ctl_d.mar_mem = 1'b1;
        ctl_d.pc_inc  = 1'b1;
      end
      S_EX: begin
        if (sto_d) begin
          ctl_d.mem_wr = 1'b1;
        end else begin
          ctl_d.mem_rd = 1'b1;
          ctl_d.acc_ld = 1'b1;
          ctl_d.alu_op = op_d;
        end
      end
      S_HALTED:   ctl_d.halted = 1'b1;
      default:    ctl_d = '0;
    endcase
    ctl_d.busy = (state_d != S_IDLE) && (state_d != S_HALTED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= 3'b000;
      sto_q   <= 1'b0;
      fault_q <= 1'b0;
      cnt_q   <= '0;
      ctl_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      sto_q   <= sto_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
      ctl_q   <= ctl_d;
    end
  end

  assign PC_INC    = ctl_q.pc_inc;
  assign MAR_PC    = ctl_q.mar_pc;
  assign MAR_MEM   = ctl_q.mar_mem;
  assign MEM_RD    = ctl_q.mem_rd;
  assign MEM_WR    = ctl_q.mem_wr;
  assign IIR       = ctl_q.iir;
  assign ACC_LD    = ctl_q.acc_ld;
  assign ALU_OP    = ctl_q.alu_op;
  assign busy      = ctl_q.busy;
  assign halted    = ctl_q.halted;
  assign fault     = fault_q;
  assign instr_cnt = cnt_q;

endmodule
